// File: rtl/traffic_generator.sv
// Avalon-MM DDR3 traffic generator: waits for calibration, writes a patterned
// block of words, reads the block back with a bounded number of reads in flight.
module traffic_generator #(
  parameter int WORD_COUNT_LOG2 = 24,
  parameter int ADDR_WIDTH      = 24,
  parameter int MAX_OUTSTANDING = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ddr3_init_done,
  input  logic                  ddr3_cal_success,
  input  logic                  ddr3_cal_fail,
  input  logic                  avl_ready,
  input  logic                  avl_rdata_valid,
  output logic                  avl_write_req,
  output logic                  avl_read_req,
  output logic                  avl_burstbegin,
  output logic [ADDR_WIDTH-1:0] avl_addr,
  output logic [63:0]           avl_wdata,
  output logic [7:0]            avl_be,
  output logic [2:0]            avl_size,
  output logic                  writes_done,
  output logic                  reads_done,
  output logic                  error
);

  typedef enum logic [2:0] {
    WAIT_INIT = 3'd0,
    WRITE     = 3'd1,
    READ      = 3'd2,
    DRAIN     = 3'd3,
    DONE      = 3'd4,
    ERROR     = 3'd5
  } state_t;

  localparam int              IW        = WORD_COUNT_LOG2 + 1;
  localparam logic [IW-1:0]   LAST_IDX  = {1'b0, {WORD_COUNT_LOG2{1'b1}}};
  localparam logic [IW-1:0]   IDX_ONE   = {{WORD_COUNT_LOG2{1'b0}}, 1'b1};
  localparam logic [7:0]      MAX_OUT   = 8'(MAX_OUTSTANDING);
  localparam logic [63:0]     DATA_SEED = 64'hdeadfadebabebeef;

  function automatic logic [ADDR_WIDTH-1:0] idx_to_addr(input logic [WORD_COUNT_LOG2-1:0] idx);
    logic [ADDR_WIDTH-1:0] a;
    a = '0;
    a[WORD_COUNT_LOG2-1:0] = idx;
    return a;
  endfunction

  function automatic logic [63:0] idx_to_data(input logic [WORD_COUNT_LOG2-1:0] idx);
    logic [63:0] d;
    d = 64'd0;
    d[WORD_COUNT_LOG2-1:0] = idx;
    return DATA_SEED ^ d;
  endfunction

  state_t        state_r, state_s;
  logic [IW-1:0] idx_r, idx_s;
  logic [7:0]    outst_r, outst_s;
  logic          wr_accept_s, rd_accept_s;
  logic          wr_req_s, rd_req_s;

  assign avl_be   = 8'hff;
  assign avl_size = 3'd1;

  // Next-state, index and outstanding-read computation; strobes come only from registers.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    wr_accept_s = avl_write_req & avl_ready;
    rd_accept_s = avl_read_req & avl_ready;
    case (state_r)
      WAIT_INIT: begin
        if (ddr3_init_done && ddr3_cal_success) begin
          state_s = WRITE;
          idx_s   = '0;
        end else if (ddr3_init_done && ddr3_cal_fail) begin
          state_s = ERROR;
        end else begin
          state_s = WAIT_INIT;
        end
      end
      WRITE: begin
        if (wr_accept_s && (idx_r == LAST_IDX)) begin
          state_s = READ;
          idx_s   = '0;
        end else if (wr_accept_s) begin
          idx_s = idx_r + IDX_ONE;
        end else begin
          idx_s = idx_r;
        end
      end
      READ: begin
        if (rd_accept_s && (idx_r == LAST_IDX)) begin
          state_s = DRAIN;
          idx_s   = '0;
        end else if (rd_accept_s) begin
          idx_s = idx_r + IDX_ONE;
        end else begin
          idx_s = idx_r;
        end
      end
      DRAIN: begin
        if (outst_r == 8'd0) begin
          state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE:    state_s = DONE;
      ERROR:   state_s = ERROR;
      default: state_s = WAIT_INIT;
    endcase

    // A stray return with nothing in flight must not wrap the counter.
    if (rd_accept_s && !avl_rdata_valid) begin
      outst_s = outst_r + 8'd1;
    end else if (!rd_accept_s && avl_rdata_valid && (outst_r != 8'd0)) begin
      outst_s = outst_r - 8'd1;
    end else begin
      outst_s = outst_r;
    end

    wr_req_s = (state_s == WRITE);
    rd_req_s = (state_s == READ) && (outst_s < MAX_OUT);
  end

  // State, counters and all Avalon/status outputs registered from next-state values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= WAIT_INIT;
      idx_r          <= '0;
      outst_r        <= 8'd0;
      avl_write_req  <= 1'b0;
      avl_read_req   <= 1'b0;
      avl_burstbegin <= 1'b0;
      avl_addr       <= '0;
      avl_wdata      <= DATA_SEED;
      writes_done    <= 1'b0;
      reads_done     <= 1'b0;
      error          <= 1'b0;
    end else begin
      state_r        <= state_s;
      idx_r          <= idx_s;
      outst_r        <= outst_s;
      avl_write_req  <= wr_req_s;
      avl_read_req   <= rd_req_s;
      avl_burstbegin <= wr_req_s | rd_req_s;
      avl_addr       <= (wr_req_s || (state_s == READ)) ? idx_to_addr(idx_s[WORD_COUNT_LOG2-1:0])
                                                        : '0;
      avl_wdata      <= idx_to_data(idx_s[WORD_COUNT_LOG2-1:0]);
      writes_done    <= writes_done | ((state_r == WRITE) && (state_s == READ));
      reads_done     <= (state_s == DONE);
      error          <= (state_s == ERROR);
    end
  end

endmodule

// File: tb/tb_traffic_generator.sv
// Directed bench for traffic_generator: scoreboard of expected write/read
// addresses, a 3-cycle-latency read responder and immediate-assertion checks.
module tb_traffic_generator;

  localparam logic [63:0] SEED = 64'hdeadfadebabebeef;

  logic        clk = 1'b0;
  logic        reset_n, ddr3_init_done, ddr3_cal_success, ddr3_cal_fail;
  logic        avl_ready, avl_rdata_valid;
  logic        avl_write_req, avl_read_req, avl_burstbegin;
  logic [23:0] avl_addr;
  logic [63:0] avl_wdata;
  logic [7:0]  avl_be;
  logic [2:0]  avl_size;
  logic        writes_done, reads_done, error;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_wr_q[$];
  int exp_rd_q[$];
  int writes_acc, reads_acc, valids_seen, model_out, withheld;
  bit withhold, ready_drv, done_checked;
  bit pend[4];

  traffic_generator #(.WORD_COUNT_LOG2(4), .ADDR_WIDTH(24), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .ddr3_init_done(ddr3_init_done), .ddr3_cal_success(ddr3_cal_success),
    .ddr3_cal_fail(ddr3_cal_fail), .avl_ready(avl_ready),
    .avl_rdata_valid(avl_rdata_valid), .avl_write_req(avl_write_req),
    .avl_read_req(avl_read_req), .avl_burstbegin(avl_burstbegin),
    .avl_addr(avl_addr), .avl_wdata(avl_wdata), .avl_be(avl_be),
    .avl_size(avl_size), .writes_done(writes_done), .reads_done(reads_done),
    .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic restart();
    exp_wr_q.delete();
    exp_rd_q.delete();
    for (int i = 0; i < 16; i++) begin
      exp_wr_q.push_back(i);
      exp_rd_q.push_back(i);
    end
    writes_acc = 0; reads_acc = 0; valids_seen = 0; model_out = 0;
    withheld = 0; done_checked = 1'b0;
    for (int i = 0; i < 4; i++) pend[i] = 1'b0;
  endtask

  // One clock: observe at the falling edge, then drive inputs for the next rising edge.
  task automatic cycle();
    int  idx;
    bit  acc_wr, acc_rd, vld;
    @(negedge clk);
    check("rd_req", avl_read_req, (writes_acc == 16 && reads_acc < 16 && model_out < 4));
    check("no_overlap", avl_write_req & avl_read_req, 1'b0);
    if (reads_done && !done_checked) begin
      done_checked = 1'b1;
      check("done_after_valids", valids_seen, 16);
    end
    for (int i = 0; i < 3; i++) pend[i] = pend[i+1];
    pend[3] = 1'b0;
    if (!withhold && withheld > 0 && !pend[0]) begin
      pend[0] = 1'b1;
      withheld--;
    end
    vld = pend[0];
    avl_rdata_valid = vld;
    avl_ready = ready_drv;
    if (vld) valids_seen++;
    acc_wr = avl_write_req && ready_drv;
    acc_rd = avl_read_req && ready_drv;
    if (acc_wr) begin
      if (exp_wr_q.size() == 0) begin
        check("wr_extra", 1'b1, 1'b0);
      end else begin
        idx = exp_wr_q.pop_front();
        check("wr_addr", avl_addr, idx);
        check("wr_data", avl_wdata, SEED ^ 64'(idx));
        writes_acc++;
      end
    end
    if (acc_rd) begin
      if (exp_rd_q.size() == 0) begin
        check("rd_extra", 1'b1, 1'b0);
      end else begin
        idx = exp_rd_q.pop_front();
        check("rd_addr", avl_addr, idx);
        reads_acc++;
      end
      if (withhold) withheld++;
      else pend[3] = 1'b1;
    end
    if (acc_rd && !vld) model_out++;
    else if (!acc_rd && vld && model_out > 0) model_out--;
  endtask

  task automatic run_writes(input int target, input int budget);
    int n = 0;
    while (writes_acc < target && n < budget) begin cycle(); n++; end
    check("writes_reached", writes_acc, target);
  endtask

  task automatic run_reads(input int target, input int budget);
    int n = 0;
    while (reads_acc < target && n < budget) begin cycle(); n++; end
    check("reads_reached", reads_acc, target);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!reads_done && n < budget) begin cycle(); n++; end
    check("reads_done_seen", reads_done, 1'b1);
  endtask

  initial begin
    reset_n = 1'b1; ddr3_init_done = 1'b0; ddr3_cal_success = 1'b0; ddr3_cal_fail = 1'b0;
    avl_ready = 1'b0; avl_rdata_valid = 1'b0; ready_drv = 1'b0; withhold = 1'b0;
    restart();
    #2 reset_n = 1'b0;
    #1;
    check("rst_wr_req", avl_write_req, 1'b0);
    check("rst_rd_req", avl_read_req, 1'b0);
    check("rst_burst", avl_burstbegin, 1'b0);
    check("rst_addr", avl_addr, 0);
    check("rst_flags", {writes_done, reads_done, error}, 3'b000);
    check("be", avl_be, 8'hff);
    check("size", avl_size, 3'd1);
    repeat (3) cycle();
    reset_n = 1'b1;
    repeat (4) cycle();
    check("wait_init_idle", avl_write_req, 1'b0);

    // Full write/read pass with a 5-cycle stall on write index 7.
    ddr3_init_done = 1'b1; ddr3_cal_success = 1'b1; ready_drv = 1'b1;
    run_writes(7, 50);
    ready_drv = 1'b0;
    repeat (5) begin
      cycle();
      check("stall_addr", avl_addr, 7);
      check("stall_data", avl_wdata, SEED ^ 64'd7);
      check("stall_req", avl_write_req, 1'b1);
      check("stall_burst", avl_burstbegin, 1'b1);
    end
    check("wd_early", writes_done, 1'b0);
    ready_drv = 1'b1;
    run_writes(16, 50);
    cycle();
    check("writes_done", writes_done, 1'b1);
    check("no_wr_in_read", avl_write_req, 1'b0);
    run_reads(16, 100);
    wait_done(100);
    check("done_valids", valids_seen, 16);
    check("done_strobes", {avl_write_req, avl_read_req, avl_burstbegin}, 3'b000);
    check("done_addr", avl_addr, 0);
    repeat (3) cycle();
    check("done_held", {writes_done, reads_done, error}, 3'b110);

    // Responder withholds returns: reads throttle at four in flight.
    reset_n = 1'b0;
    restart();
    repeat (2) cycle();
    reset_n = 1'b1;
    run_writes(16, 50);
    withhold = 1'b1;
    run_reads(4, 20);
    repeat (8) cycle();
    check("withhold_cnt", reads_acc, 4);
    check("withhold_req", avl_read_req, 1'b0);
    withhold = 1'b0;
    run_reads(16, 100);
    wait_done(100);

    // Calibration failure goes straight to a terminal error.
    reset_n = 1'b0;
    ddr3_init_done = 1'b0; ddr3_cal_success = 1'b0; ddr3_cal_fail = 1'b1;
    restart();
    repeat (2) cycle();
    reset_n = 1'b1;
    cycle();
    check("err_before", error, 1'b0);
    ddr3_init_done = 1'b1;
    cycle();
    check("err_next", error, 1'b1);
    repeat (5) begin
      cycle();
      check("err_no_req", {avl_write_req, avl_read_req, avl_burstbegin}, 3'b000);
    end
    check("err_held", error, 1'b1);

    // Success wins over fail; reset mid-write restarts from address 0.
    reset_n = 1'b0; ddr3_init_done = 1'b0;
    restart();
    repeat (2) cycle();
    reset_n = 1'b1;
    ddr3_init_done = 1'b1; ddr3_cal_success = 1'b1; ddr3_cal_fail = 1'b1;
    run_writes(9, 50);
    ready_drv = 1'b0;
    cycle();
    check("mid_addr", avl_addr, 9);
    check("mid_req", avl_write_req, 1'b1);
    check("both_no_err", error, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("async_strobes", {avl_write_req, avl_read_req, avl_burstbegin}, 3'b000);
    check("async_addr", avl_addr, 0);
    restart();
    repeat (2) cycle();
    reset_n = 1'b1;
    ready_drv = 1'b1;
    run_writes(3, 20);
    check("restart_no_err", error, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
